// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// cache_arbiter_pkg : FSM state and access-type encodings for cache_arbiter
// Revision: 1.0
// ============================================================================
package cache_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage : cache_arbiter_pkg
`default_nettype wire

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
// cache_arbiter_if : requester ports, cache control and status of cache_arbiter
// Revision: 1.0
// ============================================================================
interface cache_arbiter_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
);
  logic               p0_req;
  logic               p0_rw;
  logic [A_WIDTH-1:0] p0_addr;
  logic [D_WIDTH-1:0] p0_wdata;
  logic [D_WIDTH-1:0] p0_rdata;
  logic               p0_ack;
  logic               p0_err;

  logic               p1_req;
  logic               p1_rw;
  logic [A_WIDTH-1:0] p1_addr;
  logic [D_WIDTH-1:0] p1_wdata;
  logic [D_WIDTH-1:0] p1_rdata;
  logic               p1_ack;
  logic               p1_err;

  logic [A_WIDTH-1:0] c_addr;
  logic               c_rw;
  logic               c_ce;
  logic               c_odv;
  logic               busy;
  logic               owner;

  // Arbiter side
  modport slave (
    input  p0_req, p0_rw, p0_addr, p0_wdata,
    input  p1_req, p1_rw, p1_addr, p1_wdata,
    input  c_odv,
    output p0_rdata, p0_ack, p0_err,
    output p1_rdata, p1_ack, p1_err,
    output c_addr, c_rw, c_ce, busy, owner
  );

  // Requesters and cache side
  modport master (
    output p0_req, p0_rw, p0_addr, p0_wdata,
    output p1_req, p1_rw, p1_addr, p1_wdata,
    output c_odv,
    input  p0_rdata, p0_ack, p0_err,
    input  p1_rdata, p1_ack, p1_err,
    input  c_addr, c_rw, c_ce, busy, owner
  );

endinterface : cache_arbiter_if
`default_nettype wire

// File: rtl/cache_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : combinational two-way round-robin picker
// Revision: 1.0
// ============================================================================
module rr_pick2 (
  input  wire logic [1:0] req,
  input  wire logic       owner,
  output logic            gnt_valid,
  output logic            gnt_idx
);

  assign gnt_valid = |req;
  // On contention the port that did not hold the last grant wins
  assign gnt_idx   = (&req) ? ~owner : req[1];

endmodule : rr_pick2
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// cache_arbiter : two-port round-robin sequencer in front of a single cache,
//                 with a watchdog that terminates unacknowledged accesses.
// Revision: 1.0
// ============================================================================
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int T_WIDTH = 5,
  parameter int TIMEOUT = 16
) (
  input  wire logic         clk,
  input  wire logic         clr,
  cache_arbiter_if.slave    bus,
  inout  wire [D_WIDTH-1:0] c_data
);

  localparam logic [T_WIDTH-1:0] c_wd_last = T_WIDTH'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_owner;
  logic               r_busy;
  logic               r_c_ce;
  logic               r_c_rw;
  logic [A_WIDTH-1:0] r_c_addr;
  logic [D_WIDTH-1:0] r_wdata;
  logic [T_WIDTH-1:0] r_wd;
  logic [D_WIDTH-1:0] r_p0_rdata;
  logic [D_WIDTH-1:0] r_p1_rdata;
  logic               r_p0_ack;
  logic               r_p1_ack;
  logic               r_p0_err;
  logic               r_p1_err;

  logic               w_gnt_valid;
  logic               w_gnt_idx;
  logic               w_drive;

  rr_pick2 u_pick (
    .req       ({bus.p1_req, bus.p0_req}),
    .owner     (r_owner),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_drive = (r_state == ST_BUSY) && (r_c_rw == RW_WRITE);

  generate
    for (genvar i = 0; i < D_WIDTH; i++) begin : g_cdata_buf
      bufif1 u_buf (c_data[i], r_wdata[i], w_drive);
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b1;
      r_busy     <= 1'b0;
      r_c_ce     <= 1'b0;
      r_c_rw     <= RW_READ;
      r_c_addr   <= '0;
      r_wdata    <= '0;
      r_wd       <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_owner <= w_gnt_idx;
            r_busy  <= 1'b1;
            r_c_ce  <= 1'b1;
            r_wd    <= '0;
            r_state <= ST_BUSY;
            if (w_gnt_idx) begin
              r_c_rw   <= bus.p1_rw;
              r_c_addr <= bus.p1_addr;
              r_wdata  <= bus.p1_wdata;
            end else begin
              r_c_rw   <= bus.p0_rw;
              r_c_addr <= bus.p0_addr;
              r_wdata  <= bus.p0_wdata;
            end
          end
        end

        ST_BUSY: begin
          // A cache completion on the same edge as the watchdog expiry wins
          if (bus.c_odv) begin
            if (r_owner) begin
              r_p1_ack <= 1'b1;
              r_p1_err <= 1'b0;
              if (r_c_rw == RW_READ) r_p1_rdata <= c_data;
            end else begin
              r_p0_ack <= 1'b1;
              r_p0_err <= 1'b0;
              if (r_c_rw == RW_READ) r_p0_rdata <= c_data;
            end
            r_c_ce  <= 1'b0;
            r_state <= ST_RESP;
          end else if (r_wd == c_wd_last) begin
            if (r_owner) begin
              r_p1_ack <= 1'b1;
              r_p1_err <= 1'b1;
            end else begin
              r_p0_ack <= 1'b1;
              r_p0_err <= 1'b1;
            end
            r_c_ce  <= 1'b0;
            r_state <= ST_RESP;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end

        ST_RESP: begin
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
          r_p0_err <= 1'b0;
          r_p1_err <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_c_ce  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.p0_rdata = r_p0_rdata;
  assign bus.p0_ack   = r_p0_ack;
  assign bus.p0_err   = r_p0_err;
  assign bus.p1_rdata = r_p1_rdata;
  assign bus.p1_ack   = r_p1_ack;
  assign bus.p1_err   = r_p1_err;
  assign bus.c_addr   = r_c_addr;
  assign bus.c_rw     = r_c_rw;
  assign bus.c_ce     = r_c_ce;
  assign bus.busy     = r_busy;
  assign bus.owner    = r_owner;

endmodule : cache_arbiter
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cache_arbiter : self-checking bench for cache_arbiter with a cache model
// Revision: 1.0
// ============================================================================
module tb_cache_arbiter;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.D_WIDTH(8), .A_WIDTH(8)) bus ();
  wire [7:0] c_data;

  cache_arbiter #(
    .D_WIDTH (8),
    .A_WIDTH (8),
    .T_WIDTH (5),
    .TIMEOUT (16)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .bus    (bus),
    .c_data (c_data)
  );

  // Released bus floats high so a stray driver is visible
  generate
    for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (c_data[i]);
    end
  endgenerate

  // Cache model: odv LAT cycles after ce, read data driven while odv is high
  logic [7:0] mem [0:255];
  logic       m_odv;
  logic       m_drv_en;
  logic [7:0] m_drv_data;
  logic [1:0] m_cnt;
  logic       no_odv    = 1'b0;
  logic       stray_odv = 1'b0;

  assign c_data    = m_drv_en ? m_drv_data : 8'bz;
  assign bus.c_odv = m_odv | stray_odv;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_odv      <= 1'b0;
      m_drv_en   <= 1'b0;
      m_drv_data <= 8'h00;
      m_cnt      <= 2'd0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h04] <= 8'h02;
    end else if (bus.c_ce && !m_odv && !no_odv) begin
      if (m_cnt == 2'(LAT - 1)) begin
        m_odv <= 1'b1;
        m_cnt <= 2'd0;
        if (!bus.c_rw) begin
          m_drv_en   <= 1'b1;
          m_drv_data <= mem[bus.c_addr];
        end
      end else begin
        m_cnt <= m_cnt + 2'd1;
      end
    end else begin
      if (m_odv && bus.c_rw) mem[bus.c_addr] <= c_data;
      m_odv    <= 1'b0;
      m_drv_en <= 1'b0;
      m_cnt    <= 2'd0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected completions, checked whenever an ack appears
  typedef struct packed {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  logic prev_ack;

  always @(negedge clk) begin
    if (clr) begin
      if (prev_ack) chk("ack_one_cycle", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
      if (bus.p0_ack || bus.p1_ack) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("ack_port", {30'd0, bus.p1_ack, bus.p0_ack}, sb_e.port ? 32'd2 : 32'd1);
          chk("ack_rdata", sb_e.port ? bus.p1_rdata : bus.p0_rdata, sb_e.rdata);
          chk("ack_err", sb_e.port ? bus.p1_err : bus.p0_err, sb_e.err);
        end
      end
      prev_ack <= bus.p0_ack | bus.p1_ack;
    end else begin
      prev_ack <= 1'b0;
    end
  end

  task automatic push_exp(input logic port, input logic [7:0] rdata, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input logic port, input logic req, input logic rw,
                         input logic [7:0] a, input logic [7:0] d);
    if (!port) begin
      bus.p0_req = req; bus.p0_rw = rw; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_req = req; bus.p1_rw = rw; bus.p1_addr = a; bus.p1_wdata = d;
    end
  endtask

  // One transaction; requester inputs are scrambled after the grant
  task automatic run_txn(input logic port, input logic rw, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rdata);
    logic seen;
    seen = 1'b0;
    push_exp(port, exp_rdata, 1'b0);
    set_req(port, 1'b1, rw, a, d);
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      if (port ? bus.p1_ack : bus.p0_ack) begin
        seen = 1'b1;
      end else if (bus.c_ce) begin
        chk("busy_rw", bus.c_rw, rw);
        chk("busy_addr", bus.c_addr, a);
        if (rw) chk("busy_wdata", c_data, d);
        set_req(port, 1'b1, ~rw, ~a, ~d);
      end
    end
    if (!seen) chk("txn_ack_seen", 32'd0, 32'd1);
    chk("resp_ce_low", bus.c_ce, 1'b0);
    chk("resp_bus_released", c_data, 8'hFF);
    chk("resp_busy", bus.busy, 1'b1);
    set_req(port, 1'b0, rw, a, d);
    @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);
  endtask

  typedef struct {
    logic       port;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n0, n1, cnt;
    logic seen;

    vecs[0] = '{1'b0, 1'b0, 8'h04, 8'h00, 8'h02};
    vecs[1] = '{1'b1, 1'b1, 8'h10, 8'h04, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h04};
    vecs[3] = '{1'b1, 1'b0, 8'h04, 8'h00, 8'h02};
    vecs[4] = '{1'b1, 1'b1, 8'h20, 8'hA5, 8'h02};
    vecs[5] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'hA5};
    vecs[6] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'hA5};
    vecs[7] = '{1'b0, 1'b1, 8'h04, 8'h5A, 8'hA5};
    vecs[8] = '{1'b1, 1'b0, 8'h04, 8'h00, 8'h5A};
    vecs[9] = '{1'b0, 1'b0, 8'h55, 8'h00, 8'h00};

    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_ce", bus.c_ce, 1'b0);
    chk("rst_rw", bus.c_rw, 1'b0);
    chk("rst_addr", bus.c_addr, 8'h00);
    chk("rst_cdata_z", c_data, 8'hFF);
    chk("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 16'h0000);
    chk("rst_ack_err", {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 4'h0);
    chk("rst_owner", bus.owner, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    clr = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++)
      run_txn(vecs[v].port, vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);

    // Contention from reset: p0, then p1 (write), then p0 again
    clr = 1'b0;
    @(negedge clk);
    chk("cont_rst_owner", bus.owner, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    push_exp(1'b0, 8'h02, 1'b0);
    push_exp(1'b1, 8'h00, 1'b0);
    push_exp(1'b0, 8'h77, 1'b0);
    set_req(1'b0, 1'b1, 1'b0, 8'h04, 8'h00);
    set_req(1'b1, 1'b1, 1'b1, 8'h04, 8'h77);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 200 && !(n0 == 2 && n1 == 1); c++) begin
      @(negedge clk);
      if (bus.p0_ack) begin
        n0++;
        chk("cont_owner_p0", bus.owner, 1'b0);
        chk("cont_order_p0", n1, (n0 == 1) ? 0 : 1);
        if (n0 == 2) set_req(1'b0, 1'b0, 1'b0, 8'h04, 8'h00);
      end
      if (bus.p1_ack) begin
        n1++;
        chk("cont_owner_p1", bus.owner, 1'b1);
        chk("cont_order_p1", n0, 1);
        set_req(1'b1, 1'b0, 1'b1, 8'h04, 8'h77);
      end
    end
    chk("cont_done", {n0[3:0], n1[3:0]}, 8'h21);
    @(negedge clk);

    // Watchdog: no odv, expect ack+err after 16 BUSY cycles
    no_odv = 1'b1;
    push_exp(1'b0, 8'h77, 1'b1);
    set_req(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      if (bus.p0_ack) seen = 1'b1;
      else if (bus.c_ce) cnt++;
    end
    chk("to_ack_seen", seen, 1'b1);
    chk("to_busy_cycles", cnt, 16);
    chk("to_resp_ce", bus.c_ce, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 8'h30, 8'h00);
    @(negedge clk);
    no_odv = 1'b0;

    // Reset while BUSY aborts without an ack
    no_odv = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 8'h04, 8'h00);
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      seen = bus.c_ce;
    end
    chk("abort_ce_seen", seen, 1'b1);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("abort_ce", bus.c_ce, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_owner", bus.owner, 1'b1);
    chk("abort_cdata_z", c_data, 8'hFF);
    set_req(1'b1, 1'b0, 1'b0, 8'h04, 8'h00);
    @(negedge clk);
    clr    = 1'b1;
    no_odv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_ack", {bus.p0_ack, bus.p1_ack}, 2'b00);
    end

    // odv in IDLE must be ignored
    stray_odv = 1'b1;
    @(negedge clk);
    stray_odv = 1'b0;
    chk("stray_busy", bus.busy, 1'b0);
    chk("stray_ce", bus.c_ce, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stray_no_ack", {bus.p0_ack, bus.p1_ack, bus.busy}, 3'b000);
    end

    run_txn(1'b0, 1'b0, 8'h04, 8'h00, 8'h02);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cache_arbiter
`default_nettype wire
